alu4_arbiter: RTL and testbench
===============================

// Module: alu4_arbiter
// PURPOSE
//   Shares one ALU4 instance (8-function 4-bit ALU) between two requesters.
//   Arbitrates round-robin, captures the winner's opcode and operands, drives the ALU,
//   registers its result and returns it with the requester ID over a valid/ready response port.
//   Guards DIV/REM against a zero divisor and defines cout for every opcode.
// PARAMETERS
//   FIRST_PRIO   0        requester that wins a tie on the first arbitration after reset
//   DIVZ_RESULT  5'h1F    result returned for DIV/REM with operand2 == 0
// PORTS
//   clk          in   1  clock, rising edge
//   rst          in   1  synchronous reset, active-high
//   req0_valid   in   1  requester 0 has an operation pending
//   req0_ready   out  1  requester 0 operation accepted this cycle
//   req0_sig     in   3  requester 0 ALU opcode (OP1,ADD,SUB,DIV,REM,LSH,RSH,COM = 0..7)
//   req0_a       in   4  requester 0 operand1
//   req0_b       in   4  requester 0 operand2
//   req1_valid   in   1  requester 1 operation pending
//   req1_ready   out  1  requester 1 accepted
//   req1_sig     in   3  requester 1 opcode
//   req1_a       in   4  requester 1 operand1
//   req1_b       in   4  requester 1 operand2
//   rsp_valid    out  1  response available
//   rsp_ready    in   1  consumer takes response
//   rsp_id       out  1  requester that issued the response
//   rsp_result   out  5  ALU result
//   rsp_cout     out  1  carry/borrow (ADD/SUB only)
//   rsp_err      out  1  divide/remainder by zero
//   busy         out  1  state != IDLE
// BEHAVIOUR
//   - Reset: state=IDLE, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_cout=0, rsp_err=0, busy=0.
//     last_grant resets so that FIRST_PRIO wins the first tie.
//   - FSM, IDLE -> EXEC -> DONE -> IDLE:
//     IDLE: only one valid -> grant it; both valid -> grant !last_grant; none -> stay.
//       Granted reqN_ready=1 combinationally for exactly this cycle. Capture sig/a/b/id into
//       registers, update last_grant, go EXEC. Both reqN_ready are 0 outside IDLE.
//     EXEC: ALU inputs come from the capture registers only.
//       Register rsp_result, rsp_cout, rsp_err, rsp_id; set rsp_valid=1; go DONE.
//     DONE: hold all rsp_* stable while rsp_valid && !rsp_ready.
//       On rsp_ready: rsp_valid=0, go IDLE. No new grant in this cycle.
//   - Latency: accept edge at cycle N -> rsp_valid high from cycle N+2. Back-to-back
//     throughput is 1 op per 3 cycles with rsp_ready tied high.
//   - Requesters hold valid and payload stable until ready. Dropping valid before grant is legal.
//   - cout: ADD -> bit 4 of the 5-bit sum. SUB -> bit 4 of (a - b) mod 32 (1 when a < b).
//     All other opcodes -> 0. The ALU's own cout is not used.
//   - DIV/REM with b == 0: rsp_result = DIVZ_RESULT, rsp_err = 1, rsp_cout = 0.
//     rsp_err = 0 for all other operations.
//   - COM: result = 1 if a > b (unsigned), else 0.
//   - rst in any state aborts the operation in flight. No response is produced and no ready is issued.
// TESTING
//   - Reset: hold rst 2 cycles -> all outputs 0, busy=0, req*_ready=0.
//   - Single op: req0 ADD a=9 b=8 -> req0_ready in cycle N, rsp_valid at N+2, rsp_result=5'h11,
//     rsp_cout=1, rsp_id=0, rsp_err=0.
//   - Tie: both valid continuously (req0 SUB 3-5, req1 LSH a=7), rsp_ready=1 -> grants alternate
//     starting with FIRST_PRIO. Results are 5'h1E/cout=1 and 5'h0E/cout=0.
//   - Divide by zero: req1 DIV a=6 b=0 -> rsp_result=5'h1F, rsp_err=1. Then REM 7%3 -> 1, err=0.
//   - Backpressure: rsp_ready=0 for 5 cycles in DONE -> outputs stable, both readys 0.
//     rsp_ready=1 -> IDLE next cycle.
//   - Reset mid-op: assert rst in EXEC -> no rsp_valid follows. A subsequent request is served normally.

Source files
------------

// File: rtl/alu4_arbiter_if.sv
// Request/response bundle for the shared ALU4: two requesters, one response port and busy.
// The slave modport belongs to the arbiter; the master modport belongs to whatever drives the requests.
interface alu4_arbiter_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [2:0] req0_sig;
  logic [3:0] req0_a;
  logic [3:0] req0_b;
  logic       req1_valid;
  logic       req1_ready;
  logic [2:0] req1_sig;
  logic [3:0] req1_a;
  logic [3:0] req1_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [4:0] rsp_result;
  logic       rsp_cout;
  logic       rsp_err;
  logic       busy;

  modport slave (
    input  req0_valid, req0_sig, req0_a, req0_b,
    input  req1_valid, req1_sig, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_err, busy
  );

  modport master (
    output req0_valid, req0_sig, req0_a, req0_b,
    output req1_valid, req1_sig, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_err, busy
  );
endinterface

// File: rtl/alu4_arbiter.sv
// Round-robin sharing of one 8-function 4-bit ALU between two requesters.
// Each operation goes IDLE (grant/capture) -> EXEC (compute/register) -> DONE (hold until taken).
module alu4_arbiter #(
  parameter logic       FIRST_PRIO  = 1'b0,
  parameter logic [4:0] DIVZ_RESULT = 5'h1F
) (
  input logic           clk,
  input logic           rst,
  alu4_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_OP1 = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_REM = 3'd4;
  localparam logic [2:0] OP_LSH = 3'd5;
  localparam logic [2:0] OP_RSH = 3'd6;
  localparam logic [2:0] OP_COM = 3'd7;

  // Returns {err, cout, result[4:0]}; cout is defined here rather than taken from the ALU core.
  function automatic logic [6:0] alu4_compute(input logic [2:0] sig,
                                              input logic [3:0] a,
                                              input logic [3:0] b);
    logic [4:0] res;
    logic       cout;
    logic       err;
    res  = 5'd0;
    cout = 1'b0;
    err  = 1'b0;
    case (sig)
      OP_OP1: res = {1'b0, a};
      OP_ADD: begin
        res  = {1'b0, a} + {1'b0, b};
        cout = res[4];
      end
      OP_SUB: begin
        res  = {1'b0, a} - {1'b0, b};
        cout = res[4];
      end
      OP_DIV: begin
        if (b == 4'd0) begin
          res = DIVZ_RESULT;
          err = 1'b1;
        end else begin
          res = {1'b0, a / b};
        end
      end
      OP_REM: begin
        if (b == 4'd0) begin
          res = DIVZ_RESULT;
          err = 1'b1;
        end else begin
          res = {1'b0, a % b};
        end
      end
      OP_LSH: res = {a, 1'b0};
      OP_RSH: res = {2'b00, a[3:1]};
      OP_COM: res = {4'd0, (a > b)};
      default: res = 5'd0;
    endcase
    return {err, cout, res};
  endfunction

  state_t     state_r;
  state_t     next_state_s;
  logic       last_grant_r;
  logic       take_s;
  logic       grant_id_s;
  logic [2:0] sig_r;
  logic [3:0] a_r;
  logic [3:0] b_r;
  logic       id_r;
  logic [6:0] alu_out_s;

  // Arbitration and next-state; a grant is only issued from IDLE and never while in reset.
  always_comb begin
    next_state_s   = state_r;
    take_s         = 1'b0;
    grant_id_s     = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.req0_valid && bus.req1_valid) begin
          take_s     = 1'b1;
          grant_id_s = ~last_grant_r;
        end else if (bus.req0_valid) begin
          take_s     = 1'b1;
          grant_id_s = 1'b0;
        end else if (bus.req1_valid) begin
          take_s     = 1'b1;
          grant_id_s = 1'b1;
        end else begin
          take_s     = 1'b0;
          grant_id_s = 1'b0;
        end
        if (take_s && !rst) begin
          next_state_s   = EXEC;
          bus.req0_ready = ~grant_id_s;
          bus.req1_ready = grant_id_s;
        end else begin
          next_state_s = IDLE;
        end
      end
      EXEC: next_state_s = DONE;
      DONE: begin
        if (bus.rsp_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // ALU sees only the captured operands, never the live request buses.
  always_comb begin
    alu_out_s = alu4_compute(sig_r, a_r, b_r);
  end

  // State, capture registers and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      last_grant_r   <= ~FIRST_PRIO;
      sig_r          <= 3'd0;
      a_r            <= 4'd0;
      b_r            <= 4'd0;
      id_r           <= 1'b0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_id     <= 1'b0;
      bus.rsp_result <= 5'd0;
      bus.rsp_cout   <= 1'b0;
      bus.rsp_err    <= 1'b0;
    end else begin
      state_r <= next_state_s;
      case (state_r)
        IDLE: begin
          if (take_s) begin
            last_grant_r <= grant_id_s;
            id_r         <= grant_id_s;
            sig_r        <= grant_id_s ? bus.req1_sig : bus.req0_sig;
            a_r          <= grant_id_s ? bus.req1_a   : bus.req0_a;
            b_r          <= grant_id_s ? bus.req1_b   : bus.req0_b;
          end
        end
        EXEC: begin
          bus.rsp_valid  <= 1'b1;
          bus.rsp_id     <= id_r;
          bus.rsp_result <= alu_out_s[4:0];
          bus.rsp_cout   <= alu_out_s[5];
          bus.rsp_err    <= alu_out_s[6];
        end
        DONE: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
          end
        end
        default: bus.rsp_valid <= 1'b0;
      endcase
    end
  end

  assign bus.busy = (state_r != IDLE);

endmodule

// File: tb/tb_alu4_arbiter.sv
// Directed bench for alu4_arbiter: reset, single op, round-robin tie, divide-by-zero,
// backpressure and reset during an operation, with hand-computed expectations.
module tb_alu4_arbiter;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  alu4_arbiter_if bus ();

  alu4_arbiter #(
    .FIRST_PRIO (1'b0),
    .DIVZ_RESULT(5'h1F)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic id, input logic [4:0] res,
                         input logic cout, input logic err);
    chk1({tag, "_valid"}, bus.rsp_valid, 1'b1);
    chk1({tag, "_id"}, bus.rsp_id, id);
    chk5({tag, "_result"}, bus.rsp_result, res);
    chk1({tag, "_cout"}, bus.rsp_cout, cout);
    chk1({tag, "_err"}, bus.rsp_err, err);
  endtask

  initial begin
    logic       exp_id;
    logic [4:0] exp_res;
    logic       exp_cout;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req0_sig = 3'd1; bus.req0_a = 4'd9; bus.req0_b = 4'd8;
    bus.req1_valid = 1'b0;
    bus.req1_sig = 3'd0; bus.req1_a = 4'd0; bus.req1_b = 4'd0;
    bus.rsp_ready = 1'b1;

    // Reset: outputs clear, no ready even with a valid request pending
    tick(); tick();
    chk1("rst_valid", bus.rsp_valid, 1'b0);
    chk1("rst_id", bus.rsp_id, 1'b0);
    chk5("rst_result", bus.rsp_result, 5'd0);
    chk1("rst_cout", bus.rsp_cout, 1'b0);
    chk1("rst_err", bus.rsp_err, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_ready0", bus.req0_ready, 1'b0);
    chk1("rst_ready1", bus.req1_ready, 1'b0);

    // Single op: ADD 9+8 = 0x11, cout 1
    rst = 1'b0;
    #1;
    chk1("add_ready0", bus.req0_ready, 1'b1);
    chk1("add_ready1", bus.req1_ready, 1'b0);
    tick();
    bus.req0_valid = 1'b0;
    chk1("add_exec_busy", bus.busy, 1'b1);
    chk1("add_exec_ready0", bus.req0_ready, 1'b0);
    chk1("add_exec_valid", bus.rsp_valid, 1'b0);
    tick();
    chk_rsp("add", 1'b0, 5'h11, 1'b1, 1'b0);
    tick();
    chk1("add_idle_valid", bus.rsp_valid, 1'b0);
    chk1("add_idle_busy", bus.busy, 1'b0);

    // Fresh reset, then tie: SUB 3-5 vs LSH 7; grants alternate starting with requester 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_sig = 3'd2; bus.req0_a = 4'd3; bus.req0_b = 4'd5;
    bus.req1_valid = 1'b1; bus.req1_sig = 3'd5; bus.req1_a = 4'd7; bus.req1_b = 4'd0;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_id   = (k % 2 == 1);
      exp_res  = exp_id ? 5'h0E : 5'h1E;
      exp_cout = exp_id ? 1'b0 : 1'b1;
      chk1("tie_ready0", bus.req0_ready, ~exp_id);
      chk1("tie_ready1", bus.req1_ready, exp_id);
      tick(); tick();
      chk_rsp("tie", exp_id, exp_res, exp_cout, 1'b0);
      tick();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // Divide by zero on requester 1, then REM 7%3 and DIV 7/2
    bus.req1_valid = 1'b1; bus.req1_sig = 3'd3; bus.req1_a = 4'd6; bus.req1_b = 4'd0;
    #1;
    chk1("divz_ready1", bus.req1_ready, 1'b1);
    tick();
    bus.req1_valid = 1'b0;
    tick();
    chk_rsp("divz", 1'b1, 5'h1F, 1'b0, 1'b1);
    tick();
    bus.req1_valid = 1'b1; bus.req1_sig = 3'd4; bus.req1_a = 4'd7; bus.req1_b = 4'd3;
    tick();
    bus.req1_valid = 1'b0;
    tick();
    chk_rsp("rem", 1'b1, 5'h01, 1'b0, 1'b0);
    tick();
    bus.req0_valid = 1'b1; bus.req0_sig = 3'd3; bus.req0_a = 4'd7; bus.req0_b = 4'd2;
    tick();
    bus.req0_valid = 1'b0;
    tick();
    chk_rsp("div", 1'b0, 5'h03, 1'b0, 1'b0);
    tick();

    // Backpressure: COM 9>4 = 1, held 5 cycles with a competing request pending
    bus.rsp_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_sig = 3'd7; bus.req0_a = 4'd9; bus.req0_b = 4'd4;
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_sig = 3'd6; bus.req1_a = 4'd9; bus.req1_b = 4'd0;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk_rsp("bp", 1'b0, 5'h01, 1'b0, 1'b0);
      chk1("bp_ready0", bus.req0_ready, 1'b0);
      chk1("bp_ready1", bus.req1_ready, 1'b0);
      chk1("bp_busy", bus.busy, 1'b1);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk1("bp_take_ready1", bus.req1_ready, 1'b0);
    tick();
    chk1("bp_idle_valid", bus.rsp_valid, 1'b0);
    chk1("bp_idle_busy", bus.busy, 1'b0);
    chk1("bp_idle_ready1", bus.req1_ready, 1'b1);
    bus.req1_valid = 1'b0;

    // Reset during EXEC aborts, then an RSH 9>>1 = 4 is served normally
    bus.req0_valid = 1'b1; bus.req0_sig = 3'd1; bus.req0_a = 4'd1; bus.req0_b = 4'd2;
    tick();
    bus.req0_valid = 1'b0;
    chk1("abort_exec_busy", bus.busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk1("abort_busy", bus.busy, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk1("abort_no_valid", bus.rsp_valid, 1'b0);
      tick();
    end
    bus.req1_valid = 1'b1; bus.req1_sig = 3'd6; bus.req1_a = 4'd9; bus.req1_b = 4'd0;
    #1;
    chk1("post_ready1", bus.req1_ready, 1'b1);
    tick();
    bus.req1_valid = 1'b0;
    tick();
    chk_rsp("post_rsh", 1'b1, 5'h04, 1'b0, 1'b0);
    tick();
    chk1("post_idle_valid", bus.rsp_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
